// File: rtl/aec_pkg.sv
// aec_pkg: shared constants, state encoding and helpers for the calculator output stage.
package aec_pkg;
    localparam int RESULT_W = 7;
    localparam int LINE_MAX = 6;
    localparam logic [7:0] ZERO = 8'h30;
    localparam logic [7:0] E    = 8'h45;
    localparam logic [7:0] R    = 8'h52;
    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;

    typedef enum logic [1:0] {IDLE, CONV_H, CONV_T, EMIT} state_t;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ZERO | {4'h0, d};
    endfunction
endpackage

// File: rtl/aec_bin2dec.sv
// aec_bin2dec: sequential subtract converter, one hundreds step then repeated tens steps.
module aec_bin2dec
    import aec_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [RESULT_W-1:0] value,
    output logic                done,
    output logic                h,
    output logic [3:0]          t,
    output logic [3:0]          ones
);
    logic [RESULT_W-1:0] rem;
    logic                active;
    logic                hund;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem    <= '0;
            h      <= 1'b0;
            t      <= 4'd0;
            active <= 1'b0;
            hund   <= 1'b0;
        end else if (start) begin
            rem    <= value;
            h      <= 1'b0;
            t      <= 4'd0;
            active <= 1'b1;
            hund   <= 1'b1;
        end else if (active && hund) begin
            if (rem >= RESULT_W'(100)) begin
                rem <= rem - RESULT_W'(100);
                h   <= 1'b1;
            end
            hund <= 1'b0;
        end else if (active) begin
            if (rem >= RESULT_W'(10)) begin
                rem <= rem - RESULT_W'(10);
                t   <= t + 4'd1;
            end else begin
                active <= 1'b0;
            end
        end
    end

    assign done = active && !hund && (rem < RESULT_W'(10));
    assign ones = rem[3:0];
endmodule

// File: rtl/aec_result_fmt.sv
// aec_result_fmt: turns calculator results into ASCII lines streamed over valid/ready.
module aec_result_fmt
    import aec_pkg::*;
#(
    parameter bit EOL_CRLF = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                res_valid,
    input  logic [RESULT_W-1:0] res_value,
    input  logic                res_legal,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                overflow
);
    state_t              state, state_n;
    logic                pend_full, pend_legal;
    logic [RESULT_W-1:0] pend_val;
    logic                take, last, load, conv_done, h;
    logic [3:0]          t, ones;
    logic [7:0]          line_q [LINE_MAX];
    logic [7:0]          line_n [LINE_MAX];
    logic [7:0]          c [3];
    logic [2:0]          n, len, len_n, idx;

    assign take     = (state == IDLE) && pend_full;
    assign last     = idx == len - 3'd1;
    assign load     = (take && !pend_legal) || (state == CONV_T && conv_done);
    assign tx_valid = state == EMIT;
    assign tx_data  = tx_valid ? line_q[idx] : 8'h00;
    assign busy     = (state != IDLE) || pend_full;

    aec_bin2dec u_bin2dec (
        .clk  (clk),
        .rst  (rst),
        .start(take && pend_legal),
        .value(pend_val),
        .done (conv_done),
        .h    (h),
        .t    (t),
        .ones (ones)
    );

    // The slot may refill on the same edge the engine drains it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_full  <= 1'b0;
            pend_legal <= 1'b0;
            pend_val   <= '0;
            overflow   <= 1'b0;
        end else if (res_valid && (!pend_full || take)) begin
            pend_full  <= 1'b1;
            pend_val   <= res_value;
            pend_legal <= res_legal;
        end else begin
            if (take) pend_full <= 1'b0;
            if (res_valid) overflow <= 1'b1;
        end
    end

    // Loading in IDLE can only be the error line; otherwise digits.
    always_comb begin
        c[0] = (state == IDLE) ? E : h ? ascii_digit(4'd1) : (t != 4'd0) ? ascii_digit(t) : ascii_digit(ones);
        c[1] = (state == IDLE) ? R : h ? ascii_digit(t) : ascii_digit(ones);
        c[2] = (state == IDLE) ? R : ascii_digit(ones);
        n    = ((state == IDLE) || h) ? 3'd3 : (t != 4'd0) ? 3'd2 : 3'd1;
        for (int i = 0; i < LINE_MAX; i++) line_n[i] = 8'h00;
        for (int i = 0; i < 3; i++) if (i < int'(n)) line_n[i] = c[i];
        line_n[n] = EOL_CRLF ? CR : LF;
        if (EOL_CRLF) line_n[n + 3'd1] = LF;
        len_n = n + (EOL_CRLF ? 3'd2 : 3'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINE_MAX; i++) line_q[i] <= 8'h00;
            len <= 3'd0;
            idx <= 3'd0;
        end else if (load) begin
            line_q <= line_n;
            len    <= len_n;
            idx    <= 3'd0;
        end else if (tx_valid && tx_ready) begin
            idx <= last ? 3'd0 : idx + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (take) state_n = pend_legal ? CONV_H : EMIT;
            CONV_H:  state_n = CONV_T;
            CONV_T:  if (conv_done) state_n = EMIT;
            EMIT:    if (tx_ready && last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/aec_result_fmt.md
# aec_result_fmt

Downstream output stage of the arithmetic expression calculator. It consumes the calculator's one-cycle result pulse (7-bit value plus parentheses-legal flag) and converts it to a printable ASCII line. The line is either the unsigned decimal result without leading zeros or "ERR", followed by the end-of-line sequence. Bytes are streamed one at a time over a valid/ready handshake to the UART transmitter.

## Interface
- EOL_CRLF, 1, 1: line ends with CR (0x0D) then LF (0x0A); 0: LF only
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset rst, asynchronous, active-high
- res_valid  input  1  one-cycle pulse, result available
- res_value  input  7  calculator result, unsigned 0..127
- res_legal  input  1  1 = parentheses balanced; 0 = error (res_value ignored)
- tx_data  output  8  ASCII byte to transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  transmitter accepts byte this cycle
- busy  output  1  high unless engine IDLE and pending slot empty
- overflow  output  1  sticky; a result was dropped; cleared only by rst

## Operation
- Pending slot, 1 entry (value + legal). Captures on res_valid when empty or being drained the same edge. If full and not drained: new result dropped, overflow<=1, pending keeps its old contents.
- States: IDLE, CONV_H, CONV_T, EMIT.
- IDLE: if pending full, move it to the engine and clear the slot. Legal: rem<=value, h<=0, t<=0, go to CONV_H. Illegal: load "E","R","R",EOL into the line buffer and go to EMIT.
- CONV_H: if rem>=100 then rem<=rem-100, h<=1. Go to CONV_T. Runs exactly 1 cycle, since the hundreds digit is at most 1.
- CONV_T: if rem>=10 then rem<=rem-10, t<=t+1 and stay. Else load the line buffer and go to EMIT.
- Line buffer contents: h=1 gives digits h,t,rem. h=0 and t!=0 gives t,rem. Otherwise rem alone. Digits are 0x30+d. EOL follows the digits. Buffer is 6 bytes max, with a 3-bit length and index.
- EMIT: tx_data=buffer[idx], tx_valid=1. On tx_valid&&tx_ready, idx++. On acceptance of the last byte, go to IDLE on the same edge.
- A pending result is picked up on the next IDLE cycle.
- tx_valid never drops and tx_data never changes until the byte is accepted.
- Arithmetic: rem is 7 bits and t is 4 bits; no value exceeds its width.

## Timing
- Reset values: tx_valid 0, tx_data 0x00, busy 0, overflow 0, pending empty, state IDLE, idx 0.
- Capture edge E0. IDLE transfer at E1. Illegal result: tx_valid high after E1.
- Legal result: CONV_H at E2, then t subtract edges, then a build edge. tx_valid high after edge E(3+t). Example: value 57 gives tx_valid after E8.
- Throughput with tx_ready held high: 1 byte/cycle.
- busy rises the cycle after the res_valid capture edge. busy falls the cycle after the last byte is accepted, if pending is empty.
- Pending full while engine in IDLE: the transfer at the next edge frees the slot, so a res_valid on that same edge is captured.
- rst mid-conversion or mid-line: abort immediately. The partial line is not resumed and the pending slot is lost.

## Structure
- Shared package aec_pkg holds:
  - ASCII constants: ZERO 0x30, E 0x45, R 0x52, CR 0x0D, LF 0x0A.
  - State enum.
  - LINE_MAX=6.
  - RESULT_W=7 (shared with the calculator).
- One sub-module, aec_bin2dec: the sequential subtract converter (CONV_H/CONV_T datapath). It takes start and a 7-bit value and returns done, h, t and ones. The top level owns the pending slot, line buffer and TX handshake.

## Test plan
- Legal 57, tx_ready=1 -> bytes 0x35,0x37,0x0D,0x0A; first tx_valid 8 cycles after capture; busy low afterwards.
- Legal 0 and legal 123 -> "0",CR,LF and "1","2","3",CR,LF; no leading zeros.
- res_legal=0 with value 123 -> "E","R","R",CR,LF; tx_valid 1 cycle after transfer; overflow stays 0.
- tx_ready toggling 0/1 randomly on 100 -> tx_data/tx_valid stable while tx_ready=0; exact sequence "1","0","0",CR,LF.
- Three res_valid pulses 1 cycle apart (5, 6, 7) with tx_ready=0 -> 5 converts, 6 held pending, 7 dropped, overflow=1; releasing tx_ready outputs lines "5" then "6" only.
- rst asserted mid-EMIT of 99 -> all outputs at reset values immediately; a subsequent result 4 outputs "4",CR,LF cleanly.
